// File: rtl/riscv_memory_pkg.sv
// Shared types for the memory arbiter: FSM states, request source and the
// posted-write buffer entry layout.
package riscv_memory_pkg;

  localparam int WORD_ADDR_BITS = 30;

  typedef logic [WORD_ADDR_BITS-1:0] word_addr_t;

  typedef struct packed {
    word_addr_t  addr;
    logic [31:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ
  } arb_state_e;

  typedef enum logic {
    SRC_I,
    SRC_D
  } req_src_e;

endpackage

// File: rtl/riscv_write_buffer.sv
// Posted write buffer: FIFO ordered drain plus an associative lookup that
// returns the youngest entry matching a word address.
module riscv_write_buffer
  import riscv_memory_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  input  word_addr_t       lookup_addr_i,
  output logic             hit_o,
  output logic [31:0]      hit_data_o,
  output wb_entry_t        head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

  // A write arriving while full is dropped; the top flags the overflow.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) tail_q <= ptr_inc(tail_q);
      if (do_pop)  head_q <= ptr_inc(head_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[tail_q] <= push_entry_i;
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit_o      = 1'b0;
    hit_data_o = '0;
    idx        = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = PTR_W'((int'(head_q) + k) % DEPTH);
      if (k < int'(count_q) && mem_q[idx].addr == lookup_addr_i) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[idx].data;
      end
    end
  end

endmodule

// File: rtl/riscv_memory_arbiter.sv
// Arbitrates I-cache and D-cache traffic onto a single-outstanding RAM port,
// with posted writes, read forwarding and registered per-port responses.
module riscv_memory_arbiter
  import riscv_memory_pkg::*;
#(
  parameter  int WB_DEPTH = 4,
  localparam int CNT_W    = $clog2(WB_DEPTH + 1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  output logic [31:0] i_address_requested,
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic [31:0] d_address_requested,
  output logic        d_full,
  output logic        wb_overflow,
  output logic        ram_valid,
  output logic        ram_write,
  output logic [31:0] ram_address,
  output logic [31:0] ram_wdata,
  input  logic        ram_accept,
  input  logic        ram_rvalid,
  input  logic [31:0] ram_rdata
);

  localparam logic [CNT_W-1:0] DRAIN_HI = CNT_W'(WB_DEPTH - 1);

  arb_state_e       state_q;
  req_src_e         src_q;
  word_addr_t       req_addr_q;
  logic             ram_valid_q, ram_write_q;
  logic [31:0]      ram_address_q, ram_wdata_q;

  logic             i_ready_q, i_ready_d;
  logic [31:0]      i_rdata_q, i_rdata_d, i_addr_q, i_addr_d;
  logic             d_ready_q, d_ready_d, d_rd_resp_q, d_rd_resp_d;
  logic [31:0]      d_rdata_q, d_rdata_d, d_addr_q, d_addr_d;
  logic             d_pend_q, d_pend_d;
  logic [31:0]      d_pend_data_q, d_pend_data_d, d_pend_addr_q, d_pend_addr_d;
  logic             wb_overflow_q;

  logic             wb_hit, wb_full, wb_empty, wb_pop;
  logic [31:0]      wb_hit_data;
  wb_entry_t        wb_head;
  logic [CNT_W-1:0] wb_count;

  logic             drain_hi, rd_d, rd_i, idle_rd, fwd, ram_rsp, drain_now;
  logic             new_d_v, new_i_v;
  logic [31:0]      rsp_data, rsp_addr;
  word_addr_t       lookup_addr;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{i_address[1:0], d_address[1:0]};

  riscv_write_buffer #(.DEPTH(WB_DEPTH)) u_wb (
    .clock        (clock),
    .reset        (reset),
    .push_i       (d_write),
    .push_entry_i ('{addr: d_address[31:2], data: d_wdata}),
    .pop_i        (wb_pop),
    .lookup_addr_i(lookup_addr),
    .hit_o        (wb_hit),
    .hit_data_o   (wb_hit_data),
    .head_o       (wb_head),
    .count_o      (wb_count),
    .full_o       (wb_full),
    .empty_o      (wb_empty)
  );

  // A port whose response is on the wire this cycle still holds its level
  // request; ignore it for one cycle so the same read is not served twice.
  assign rd_d        = d_read && !(d_pend_q || (d_ready_q && d_rd_resp_q));
  assign rd_i        = i_read && !i_ready_q;
  assign lookup_addr = rd_d ? d_address[31:2] : i_address[31:2];

  assign drain_hi  = (wb_count >= DRAIN_HI);
  assign idle_rd   = (state_q == ST_IDLE) && !drain_hi && (rd_d || rd_i);
  assign fwd       = idle_rd && wb_hit;
  assign ram_rsp   = (state_q == ST_RD_WAIT) && ram_rvalid;
  assign drain_now = (state_q == ST_IDLE) && (drain_hi || (!idle_rd && !wb_empty));
  assign wb_pop    = (state_q == ST_WR_REQ) && ram_accept;

  assign new_d_v  = (fwd && rd_d) || (ram_rsp && src_q == SRC_D);
  assign new_i_v  = (fwd && !rd_d) || (ram_rsp && src_q == SRC_I);
  assign rsp_data = fwd ? wb_hit_data : ram_rdata;
  assign rsp_addr = fwd ? {lookup_addr, 2'b00} : {req_addr_q, 2'b00};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      src_q         <= SRC_I;
      req_addr_q    <= '0;
      ram_valid_q   <= 1'b0;
      ram_write_q   <= 1'b0;
      ram_address_q <= '0;
      ram_wdata_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (drain_now) begin
            state_q       <= ST_WR_REQ;
            ram_valid_q   <= 1'b1;
            ram_write_q   <= 1'b1;
            ram_address_q <= {wb_head.addr, 2'b00};
            ram_wdata_q   <= wb_head.data;
          end else if (idle_rd && !wb_hit) begin
            state_q       <= ST_RD_REQ;
            ram_valid_q   <= 1'b1;
            ram_write_q   <= 1'b0;
            ram_address_q <= {lookup_addr, 2'b00};
            req_addr_q    <= lookup_addr;
            src_q         <= rd_d ? SRC_D : SRC_I;
          end
        end
        ST_RD_REQ: begin
          if (ram_accept) begin
            state_q     <= ST_RD_WAIT;
            ram_valid_q <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          if (ram_rvalid) state_q <= ST_IDLE;
        end
        ST_WR_REQ: begin
          if (ram_accept) begin
            state_q     <= ST_IDLE;
            ram_valid_q <= 1'b0;
            ram_write_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    i_ready_d     = new_i_v;
    i_rdata_d     = new_i_v ? rsp_data : i_rdata_q;
    i_addr_d      = new_i_v ? rsp_addr : i_addr_q;
    d_ready_d     = 1'b0;
    d_rd_resp_d   = 1'b0;
    d_rdata_d     = d_rdata_q;
    d_addr_d      = d_addr_q;
    d_pend_d      = d_pend_q;
    d_pend_data_d = d_pend_data_q;
    d_pend_addr_d = d_pend_addr_q;
    // Write acks win the D port; a colliding read response waits one cycle.
    if (d_write) begin
      d_ready_d = 1'b1;
      d_addr_d  = {d_address[31:2], 2'b00};
      if (new_d_v) begin
        d_pend_d      = 1'b1;
        d_pend_data_d = rsp_data;
        d_pend_addr_d = rsp_addr;
      end
    end else if (d_pend_q) begin
      d_ready_d   = 1'b1;
      d_rd_resp_d = 1'b1;
      d_rdata_d   = d_pend_data_q;
      d_addr_d    = d_pend_addr_q;
      d_pend_d    = 1'b0;
    end else if (new_d_v) begin
      d_ready_d   = 1'b1;
      d_rd_resp_d = 1'b1;
      d_rdata_d   = rsp_data;
      d_addr_d    = rsp_addr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      i_ready_q     <= 1'b0;
      i_rdata_q     <= '0;
      i_addr_q      <= '0;
      d_ready_q     <= 1'b0;
      d_rd_resp_q   <= 1'b0;
      d_rdata_q     <= '0;
      d_addr_q      <= '0;
      d_pend_q      <= 1'b0;
      d_pend_data_q <= '0;
      d_pend_addr_q <= '0;
      wb_overflow_q <= 1'b0;
    end else begin
      i_ready_q     <= i_ready_d;
      i_rdata_q     <= i_rdata_d;
      i_addr_q      <= i_addr_d;
      d_ready_q     <= d_ready_d;
      d_rd_resp_q   <= d_rd_resp_d;
      d_rdata_q     <= d_rdata_d;
      d_addr_q      <= d_addr_d;
      d_pend_q      <= d_pend_d;
      d_pend_data_q <= d_pend_data_d;
      d_pend_addr_q <= d_pend_addr_d;
      wb_overflow_q <= wb_overflow_q || (d_write && wb_full);
    end
  end

  assign i_ready             = i_ready_q;
  assign i_rdata             = i_rdata_q;
  assign i_address_requested = i_addr_q;
  assign d_ready             = d_ready_q;
  assign d_rdata             = d_rdata_q;
  assign d_address_requested = d_addr_q;
  assign d_full              = wb_full;
  assign wb_overflow         = wb_overflow_q;
  assign ram_valid           = ram_valid_q;
  assign ram_write           = ram_write_q;
  assign ram_address         = ram_address_q;
  assign ram_wdata           = ram_wdata_q;

endmodule

// File: tb/tb_riscv_memory_arbiter.sv
// Directed bench for riscv_memory_arbiter with a zero-wait RAM model that
// returns (address ^ 0x5A5A0000) for reads and logs every accepted write.
module tb_riscv_memory_arbiter;

  localparam logic [31:0] K = 32'h5A5A_0000;

  logic        clock, reset;
  logic [31:0] i_address, i_rdata, i_address_requested;
  logic        i_read, i_ready;
  logic [31:0] d_address, d_wdata, d_rdata, d_address_requested;
  logic        d_read, d_write, d_ready, d_full, wb_overflow;
  logic        ram_valid, ram_write, ram_accept, ram_rvalid;
  logic [31:0] ram_address, ram_wdata, ram_rdata;

  logic        model_en, man_rvalid;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata  = '0;
  logic [31:0] log_addr [16];
  logic [31:0] log_data [16];
  int          wr_cnt = 0;

  int tests_run    = 0;
  int tests_failed = 0;

  riscv_memory_arbiter #(.WB_DEPTH(4)) dut (
    .clock              (clock),
    .reset              (reset),
    .i_address          (i_address),
    .i_read             (i_read),
    .i_rdata            (i_rdata),
    .i_ready            (i_ready),
    .i_address_requested(i_address_requested),
    .d_address          (d_address),
    .d_read             (d_read),
    .d_write            (d_write),
    .d_wdata            (d_wdata),
    .d_rdata            (d_rdata),
    .d_ready            (d_ready),
    .d_address_requested(d_address_requested),
    .d_full             (d_full),
    .wb_overflow        (wb_overflow),
    .ram_valid          (ram_valid),
    .ram_write          (ram_write),
    .ram_address        (ram_address),
    .ram_wdata          (ram_wdata),
    .ram_accept         (ram_accept),
    .ram_rvalid         (ram_rvalid),
    .ram_rdata          (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign ram_rvalid = m_rvalid | man_rvalid;
  assign ram_rdata  = model_en ? m_rdata : 32'hBAD0_BAD0;

  always @(posedge clock) begin
    if (ram_valid && ram_accept && !ram_write && model_en) begin
      m_rvalid <= 1'b1;
      m_rdata  <= ram_address ^ K;
    end else begin
      m_rvalid <= 1'b0;
    end
    if (ram_valid && ram_accept && ram_write && wr_cnt < 16) begin
      log_addr[wr_cnt] <= ram_address;
      log_data[wr_cnt] <= ram_wdata;
      wr_cnt           <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    exp_a = '{32'h10, 32'h14, 32'h18, 32'h1C};
    exp_d = '{32'h11, 32'h22, 32'h33, 32'h44};

    reset = 1'b1; i_address = '0; i_read = 1'b0; d_address = '0; d_read = 1'b0;
    d_write = 1'b0; d_wdata = '0; ram_accept = 1'b0; model_en = 1'b1; man_rvalid = 1'b0;
    tick(2);
    check("rst_i_ready",   32'(i_ready),   32'd0);
    check("rst_d_ready",   32'(d_ready),   32'd0);
    check("rst_ram_valid", 32'(ram_valid), 32'd0);
    check("rst_ram_write", 32'(ram_write), 32'd0);
    check("rst_overflow",  32'(wb_overflow), 32'd0);
    check("rst_d_full",    32'(d_full),    32'd0);
    check("rst_d_rdata",   d_rdata,        32'd0);
    check("rst_ram_addr",  ram_address,    32'd0);
    reset = 1'b0;
    tick();

    // Posted write then forwarded read with RAM stalled
    d_address = 32'h100; d_wdata = 32'hDEADBEEF; d_write = 1'b1;
    tick();
    d_write = 1'b0;
    check("wr_ack",        32'(d_ready),        32'd1);
    check("wr_ack_addr",   d_address_requested, 32'h100);
    check("wr_no_ram",     32'(ram_valid),      32'd0);
    d_read = 1'b1;
    tick();
    check("fwd_ready",     32'(d_ready),        32'd1);
    check("fwd_data",      d_rdata,             32'hDEADBEEF);
    check("fwd_addr",      d_address_requested, 32'h100);
    check("fwd_no_ram",    32'(ram_valid),      32'd0);
    d_read = 1'b0;
    tick();
    check("fwd_pulse_end", 32'(d_ready),   32'd0);
    check("drain_valid",   32'(ram_valid), 32'd1);
    check("drain_write",   32'(ram_write), 32'd1);
    check("drain_addr",    ram_address,    32'h100);
    check("drain_wdata",   ram_wdata,      32'hDEADBEEF);
    tick();
    check("drain_stable",  ram_address,    32'h100);
    ram_accept = 1'b1;
    tick();
    check("drain_done",    32'(ram_valid), 32'd0);
    check("log0_cnt",      32'(wr_cnt),    32'd1);
    check("log0_addr",     log_addr[0],    32'h100);
    check("log0_data",     log_data[0],    32'hDEADBEEF);

    // Simultaneous I and D reads, D wins
    i_address = 32'h200; i_read = 1'b1; d_address = 32'h300; d_read = 1'b1;
    tick();
    check("dr_ram_valid",  32'(ram_valid), 32'd1);
    check("dr_ram_write",  32'(ram_write), 32'd0);
    check("dr_ram_addr",   ram_address,    32'h300);
    tick(2);
    check("dr_ready",      32'(d_ready),        32'd1);
    check("dr_data",       d_rdata,             32'h5A5A0300);
    check("dr_addr",       d_address_requested, 32'h300);
    check("dr_no_i",       32'(i_ready),        32'd0);
    check("dr_i_addr",     i_address_requested, 32'h0);
    d_read = 1'b0;
    tick();
    check("ir_ram_addr",   ram_address,    32'h200);
    tick(2);
    check("ir_ready",      32'(i_ready),        32'd1);
    check("ir_data",       i_rdata,             32'h5A5A0200);
    check("ir_addr",       i_address_requested, 32'h200);
    check("ir_no_d",       32'(d_ready),        32'd0);
    check("ir_d_addr",     d_address_requested, 32'h300);
    i_read = 1'b0;

    // Fill buffer with RAM stalled, then overflow
    ram_accept = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d_address = 32'h10 + 32'(4 * i); d_wdata = 32'(32'h11 * (i + 1)); d_write = 1'b1;
      tick();
    end
    check("full_flag",     32'(d_full),         32'd1);
    check("full_ack_addr", d_address_requested, 32'h1C);
    check("full_head",     ram_address,         32'h10);
    d_address = 32'h20; d_wdata = 32'h55;
    tick();
    d_write = 1'b0;
    check("ovf_flag",      32'(wb_overflow),    32'd1);
    check("ovf_ack",       32'(d_ready),        32'd1);
    check("ovf_ack_addr",  d_address_requested, 32'h20);
    check("ovf_full",      32'(d_full),         32'd1);
    check("ovf_head_data", ram_wdata,           32'h11);
    ram_accept = 1'b1;
    tick(8);
    check("drain4_cnt",    32'(wr_cnt),      32'd5);
    check("drain4_empty",  32'(d_full),      32'd0);
    check("ovf_sticky",    32'(wb_overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain4_addr%0d", i), log_addr[i + 1], exp_a[i]);
      check($sformatf("drain4_data%0d", i), log_data[i + 1], exp_d[i]);
    end

    // Two writes to one word queued behind a stalled I read; youngest wins
    ram_accept = 1'b0; i_address = 32'h80; i_read = 1'b1;
    tick();
    d_address = 32'h40; d_wdata = 32'h1; d_write = 1'b1;
    tick();
    d_wdata = 32'h2;
    tick();
    d_write = 1'b0; d_read = 1'b1; ram_accept = 1'b1;
    tick(2);
    check("yi_ready",      32'(i_ready),        32'd1);
    check("yi_data",       i_rdata,             32'h5A5A0080);
    check("yi_addr",       i_address_requested, 32'h80);
    i_read = 1'b0;
    tick();
    check("young_ready",   32'(d_ready),        32'd1);
    check("young_data",    d_rdata,             32'h2);
    check("young_addr",    d_address_requested, 32'h40);
    check("young_no_ram",  32'(ram_valid),      32'd0);
    d_read = 1'b0;
    tick(6);
    check("young_cnt",     32'(wr_cnt),  32'd7);
    check("young_log5",    log_data[5],  32'h1);
    check("young_log6",    log_data[6],  32'h2);
    check("young_log6a",   log_addr[6],  32'h40);

    // Reset while waiting for read data; late rvalid must be ignored
    model_en = 1'b0; d_address = 32'h500; d_read = 1'b1;
    tick();
    check("rw_req_addr",   ram_address, 32'h500);
    tick();
    reset = 1'b1; d_read = 1'b0;
    tick();
    reset = 1'b0; man_rvalid = 1'b1;
    tick();
    man_rvalid = 1'b0;
    check("rw_i_ready",    32'(i_ready),        32'd0);
    check("rw_d_ready",    32'(d_ready),        32'd0);
    check("rw_d_rdata",    d_rdata,             32'd0);
    check("rw_d_addr",     d_address_requested, 32'd0);
    check("rw_i_rdata",    i_rdata,             32'd0);
    check("rw_i_addr",     i_address_requested, 32'd0);
    check("rw_ram_valid",  32'(ram_valid),      32'd0);
    check("rw_ram_addr",   ram_address,         32'd0);
    check("rw_overflow",   32'(wb_overflow),    32'd0);
    model_en = 1'b1;
    tick();

    // Write ack collides with a returning D read
    d_address = 32'h600; d_read = 1'b1;
    tick(2);
    d_wdata = 32'h77; d_write = 1'b1;
    tick();
    d_write = 1'b0;
    check("col_ack",       32'(d_ready),        32'd1);
    check("col_ack_addr",  d_address_requested, 32'h600);
    tick();
    d_read = 1'b0;
    check("col_rd_ready",  32'(d_ready),        32'd1);
    check("col_rd_data",   d_rdata,             32'h5A5A0600);
    tick();
    check("col_done",      32'(d_ready),        32'd0);
    tick(2);
    check("col_log_cnt",   32'(wr_cnt),  32'd8);
    check("col_log_data",  log_data[7],  32'h77);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
